// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: MEM-stage store/load ports, RAM port and queue status.
// The buffer takes the slave side; the pipeline/RAM environment takes the master side.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_fwd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_datain;
    logic          mem_we;
    logic [DW-1:0] mem_dataout;
    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_dataout,
        output st_ready, ld_data, ld_fwd, mem_addr, mem_datain, mem_we, count, empty
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_dataout,
        input  st_ready, ld_data, ld_fwd, mem_addr, mem_datain, mem_we, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Write-posting store queue in front of a single-port word RAM. Stores drain
// oldest-first whenever no load owns the RAM port; loads forward from the youngest match.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic           clk,
    input logic           clrn,
    store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = AW - 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [WW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        entry_q [DEPTH];
    entry_t        entry_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;

    logic          enq_s;
    logic          drn_s;
    logic          fwd_hit_s;
    logic [DW-1:0] fwd_data_s;
    logic [PW-1:0] fwd_idx_s;
    logic          unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

    // Accept/drain decisions; a load always wins the RAM port
    always_comb begin
        enq_s = sb.st_valid && !full_q;
        drn_s = !empty_q && !sb.ld_valid;
    end

    // Queue next state: enqueue at tail, retire at head, track occupancy
    always_comb begin
        entry_d = entry_q;
        if (enq_s) begin
            entry_d[tail_q] = '{addr: sb.st_addr[AW-1:2], data: sb.st_data};
        end else begin
            entry_d[tail_q] = entry_q[tail_q];
        end

        if (enq_s) begin
            tail_d = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end

        if (drn_s) begin
            head_d = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end

        case ({enq_s, drn_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == {CW{1'b0}});
        full_d  = (count_d == FULL_CNT);
    end

    // Forwarding search from oldest to youngest so the last hit is the youngest
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = {DW{1'b0}};
        fwd_idx_s  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = head_q + PW'(i);
            if ((CW'(i) < count_q) && (entry_q[fwd_idx_s].addr == sb.ld_addr[AW-1:2])) begin
                fwd_hit_s  = 1'b1;
                fwd_data_s = entry_q[fwd_idx_s].data;
            end else begin
                fwd_hit_s  = fwd_hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // RAM port steering and load result selection
    always_comb begin
        if (sb.ld_valid) begin
            sb.mem_addr = {sb.ld_addr[AW-1:2], 2'b00};
            sb.mem_we   = 1'b0;
        end else begin
            sb.mem_addr = {entry_q[head_q].addr, 2'b00};
            sb.mem_we   = !empty_q;
        end
        sb.mem_datain = entry_q[head_q].data;

        if (sb.ld_valid && fwd_hit_s) begin
            sb.ld_fwd  = 1'b1;
            sb.ld_data = fwd_data_s;
        end else begin
            sb.ld_fwd  = 1'b0;
            sb.ld_data = sb.mem_dataout;
        end
    end

    // Status outputs come straight from registered state
    always_comb begin
        sb.count    = count_q;
        sb.empty    = empty_q;
        sb.st_ready = !full_q;
    end

    // Queue state registers; reset discards every pending store
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '{addr: {WW{1'b0}}, data: {DW{1'b0}}};
            end
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end
endmodule
